in_channel: RTL
===============

# in_channel

Input-channel buffer that feeds the program-execution core's `in` and `inSize` instructions. External logic pushes words through a valid/ready load port. The core reads the number of words still available (`inSize`) and pops one word per `in` instruction. Read data returns one cycle after the request, with a hit/miss indication. The block replaces the fixed preloaded input array with a real FIFO, so test programs can be streamed input at run time.

## Interface
- `MemoryElementWidth`, 12: width of each channel word and of `inSize`.
- `NIn`, 16: channel depth in words; any value from 2 to 2^MemoryElementWidth−1.
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `loadValid`  in  1  producer offers `loadData`.
- `loadData`  in  MemoryElementWidth  word to append.
- `loadReady`  out  1  channel can accept a word this cycle.
- `inReq`  in  1  core executes `in`; a one-cycle pulse requests a pop.
- `inAck`  out  1  one-cycle pulse, exactly one cycle after each `inReq`.
- `inHit`  out  1  qualifies `inAck`: 1 = `inData` holds the popped word; 0 = channel was empty.
- `inData`  out  MemoryElementWidth  popped word; holds its last value on a miss.
- `inSize`  out  MemoryElementWidth  words currently held; serves the `inSize` instruction.
- `underflow`  out  1  sticky flag; present only when `IN_CHANNEL_UNDERFLOW_EN` is defined.

## Operation
- **Storage:** circular buffer of NIn words with write pointer `wp`, read pointer `rp` and occupancy `count` (0..NIn).
  - Pointers wrap from NIn−1 to 0 by explicit compare, not modulo-power-of-two, so non-power-of-two depths work.
- **Push:** occurs when `loadValid && loadReady`.
  - `loadReady = (count < NIn)`, taken combinationally from registered `count` only. It never depends on `inReq`.
  - A full channel therefore refuses a push even when a pop happens in the same cycle.
- **Pop:** `inReq` is evaluated against `count` as it stood before the edge.
  - If `count > 0`: the head word is registered into `inData`; `inHit` = 1; `rp` advances.
  - If `count == 0`: `inHit` = 0 and `inData` is unchanged. This matches the core's rule that `in` on an exhausted channel leaves its target untouched.
- **Simultaneous push and pop:**
  - Non-empty: `count` is unchanged and both pointers advance.
  - Empty: the pop misses, the push lands, and `count` becomes 1.
- **inSize:** equals registered `count`, updated on the same edge as a push or pop.
- **Protocol:** `inReq` on consecutive cycles is legal; each request gets its own ack in order. There are no other states.

## Timing
- All outputs are registered except `loadReady`, which is a combinational compare of a registered value.
- Pop latency is 1 cycle: `inReq` sampled at edge N produces `inAck`/`inHit`/`inData` valid after edge N, for one cycle.
- Push-to-visible latency is 1 cycle: a word pushed at edge N is counted in `inSize` after edge N and can be popped by an `inReq` sampled at edge N+1.
- Reset values: `count` = 0, `wp` = `rp` = 0, `inAck` = 0, `inHit` = 0, `inData` = 0, `inSize` = 0, `underflow` = 0. Consequently `loadReady` = 1 after reset.
- Reset mid-operation: reset wins over any push or pop in the same cycle.
  - Buffered words are discarded.
  - An `inReq` sampled with `reset` high produces no `inAck`.
  - Storage contents are not cleared; they are unreachable because `count` = 0.

## Configuration
- `IN_CHANNEL_UNDERFLOW_EN` defined:
  - The `underflow` port exists.
  - It is set on the edge of any missed pop (`inReq` with `count == 0`).
  - It stays set until `reset`.
- Not defined: the port and its register are absent. A missed pop is visible only through `inHit` = 0.

## Structure
- Shared package `fpga_pkg`: `MemoryElementWidth` constant, `word_t` typedef, and the `count_t` typedef (MemoryElementWidth bits wide). The core's `inSize` path uses the same `count_t`.
- Sub-module `in_channel_ram`:
  - NIn × MemoryElementWidth array.
  - One synchronous write port.
  - One synchronous read port whose registered output drives `inData` directly.
- Pointer, count, handshake and flag logic stays in `in_channel`.

## Test plan
- **Basic push/pop:** after reset, push 88 then 44, then pulse `inReq` three times on consecutive cycles.
  - Acks: (hit, 88), (hit, 44), (miss, data still 44).
  - `inSize` sequence: 2, 1, 0, 0.
  - `underflow` = 1 when the macro is defined.
- **Fill to capacity:** push NIn words 1..NIn.
  - `loadReady` drops after the NIn-th push, and an extra push with `loadValid` held is not taken.
  - One pop returns 1; `loadReady` returns next cycle; pushing 99 then draining yields 2..NIn, 99.
- **Wrap-around:** with NIn = 5, run 12 rounds of push-3/pop-3 using distinct values. Every word returns in order and `inSize` never exceeds 3.
- **Simultaneous push and pop:**
  - On an empty channel, push 7 with `inReq`: miss, `inSize` = 1; the next pop hits with 7.
  - With 2 words held, push and pop together: `inSize` stays 2 and the head word is returned.
- **Reset mid-operation:** with 3 words held, assert `reset` together with `inReq` and a push.
  - No `inAck` follows; `inSize` = 0 and `loadReady` = 1.
  - A subsequent pop misses.

Source files
------------

// File: rtl/fpga_pkg.sv
// Shared definitions for the program-execution core and its peripherals.
//   MemoryElementWidth : width of every memory / channel word
//   word_t             : one channel or memory word
//   count_t            : occupancy / size value (same width as a word, so the
//                        core can move inSize straight into a register)
package fpga_pkg;

  localparam int unsigned MemoryElementWidth = 12;

  typedef logic [MemoryElementWidth-1:0] word_t;
  typedef logic [MemoryElementWidth-1:0] count_t;

endpackage

// File: rtl/in_channel_ram.sv
// Storage array for in_channel: NIn words, one synchronous write port and one
// synchronous read port. The read register is the channel's inData output, so
// it only loads on a read and otherwise holds its last value.
// Ports:
//   clock, reset : clock and synchronous active-high reset (clears rdata only)
//   we/waddr/wdata : write port
//   re/raddr/rdata : read port, rdata valid the cycle after re
module in_channel_ram
  import fpga_pkg::*;
#(
  parameter int unsigned NIn       = 16,
  parameter int unsigned AddrWidth = $clog2(NIn)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  word_t                wdata,
  input  logic                 re,
  input  logic [AddrWidth-1:0] raddr,
  output word_t                rdata
);

  word_t mem [NIn];

  // Array contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/in_channel.sv
// Input-channel FIFO feeding the core's `in` / `inSize` instructions.
// Producer pushes words over a valid/ready port; the core pops one word per
// inReq and gets inAck/inHit/inData one cycle later. A pop on an empty channel
// acks with inHit = 0 and leaves inData untouched.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   loadValid/loadData    : push request and word
//   loadReady             : channel not full (combinational from count)
//   inReq                 : pop request pulse
//   inAck/inHit/inData    : registered pop response
//   inSize                : registered occupancy
//   underflow             : sticky missed-pop flag, only when the macro
//                           IN_CHANNEL_UNDERFLOW_EN is defined
// NIn may be any value from 2 to 2**MemoryElementWidth-1.
module in_channel
  import fpga_pkg::*;
#(
  parameter int unsigned NIn = 16
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   loadValid,
  input  word_t  loadData,
  output logic   loadReady,
  input  logic   inReq,
  output logic   inAck,
  output logic   inHit,
  output word_t  inData,
  output count_t inSize
`ifdef IN_CHANNEL_UNDERFLOW_EN
  ,
  output logic   underflow
`endif
);

  localparam int unsigned AddrWidth = $clog2(NIn);
  localparam logic [AddrWidth-1:0] LastPtr = AddrWidth'(NIn - 1);

  logic [AddrWidth-1:0] wp_q, wp_d, rp_q, rp_d;
  count_t               count_q, count_d;
  logic                 ack_q, hit_q;
  logic                 push, pop;

  // Ready looks only at registered count: a full channel refuses a push even
  // when a pop frees a slot in the same cycle.
  assign loadReady = (count_q < count_t'(NIn));
  assign push      = loadValid && loadReady;
  assign pop       = inReq && (count_q != '0);

  // Explicit wrap so non-power-of-two depths work.
  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (push) begin
      wp_d = (wp_q == LastPtr) ? '0 : wp_q + AddrWidth'(1);
    end
    if (pop) begin
      rp_d = (rp_q == LastPtr) ? '0 : rp_q + AddrWidth'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + count_t'(1);
      2'b01:   count_d = count_q - count_t'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ack_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ack_q   <= inReq;
      hit_q   <= pop;
    end
  end

`ifdef IN_CHANNEL_UNDERFLOW_EN
  logic underflow_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_q <= 1'b0;
    end else if (inReq && (count_q == '0)) begin
      underflow_q <= 1'b1;
    end
  end

  assign underflow = underflow_q;
`endif

  in_channel_ram #(
    .NIn       (NIn),
    .AddrWidth (AddrWidth)
  ) u_ram (
    .clock (clock),
    .reset (reset),
    .we    (push),
    .waddr (wp_q),
    .wdata (loadData),
    .re    (pop),
    .raddr (rp_q),
    .rdata (inData)
  );

  assign inAck  = ack_q;
  assign inHit  = hit_q;
  assign inSize = count_q;

endmodule
